// File: rtl/ysyx_22041071_lsu_pkg.sv
// Shared constants for the load/store unit: RV funct3/opcode encodings,
// FSM state encoding and the default physical memory base.
package ysyx_22041071_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    localparam logic [63:0] MEM_BASE_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_OUT  = 2'd3
    } lsu_state_e;

    // Number of bytes touched by an access of the given funct3 (1, 2, 4 or 8).
    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/ysyx_22041071_lsu_align.sv
// Combinational lane steering: store data/strobe generation and load
// lane selection with sign/zero extension.
module ysyx_22041071_lsu_align
    import ysyx_22041071_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W = $clog2(STRB_W)
) (
    input  logic [2:0]        st_funct3,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [XLEN-1:0]   st_data,
    output logic [STRB_W-1:0] st_strb,
    input  logic [2:0]        ld_funct3,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data
);

    // Offset bits below the access size are dropped, so an unaligned
    // access lands on the enclosing naturally aligned lane.
    function automatic logic [OFF_W-1:0] trunc_off(input logic [2:0] f3, input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] mask;
        mask = OFF_W'(access_bytes(f3) - 4'd1);
        return off & ~mask;
    endfunction

    logic [OFF_W-1:0] st_aoff;
    logic [OFF_W-1:0] ld_aoff;
    logic [OFF_W:0]   st_end;
    logic             st_legal;
    logic [XLEN-1:0]  ld_shift;

    assign st_aoff  = trunc_off(st_funct3, st_off);
    assign st_end   = {1'b0, st_aoff} + (OFF_W+1)'(access_bytes(st_funct3));
    assign st_legal = !st_funct3[2] && ((st_funct3[1:0] != 2'b11) || (XLEN == 64));
    assign st_data  = st_wdata << {st_aoff, 3'b000};

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
        assign st_strb[gi] = st_legal
                          && ((OFF_W+1)'(gi) >= {1'b0, st_aoff})
                          && ((OFF_W+1)'(gi) < st_end);
    end

    assign ld_aoff  = trunc_off(ld_funct3, ld_off);
    assign ld_shift = ld_rdata >> {ld_aoff, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_funct3)
            F3_LB:  ld_data = XLEN'($signed(ld_shift[7:0]));
            F3_LH:  ld_data = XLEN'($signed(ld_shift[15:0]));
            F3_LW:  ld_data = XLEN'($signed(ld_shift[31:0]));
            F3_LBU: ld_data = XLEN'(ld_shift[7:0]);
            F3_LHU: ld_data = XLEN'(ld_shift[15:0]);
            F3_LWU: if (XLEN == 64) ld_data = XLEN'(ld_shift[31:0]);
            F3_LD:  if (XLEN == 64) ld_data = ld_shift;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041071_lsu.sv
// Load/store unit between EX and WB: one instruction per handshake, word
// requests with byte strobes, variable-latency responses, held output register.
// Optional misaligned-access trap: define YSYX_22041071_MISALIGN_TRAP_EN.
module ysyx_22041071_lsu
    import ysyx_22041071_lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] MEM_BASE = XLEN'(MEM_BASE_DEFAULT),
    parameter int IDX_W = 61
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [31:0]         in_ins,
    input  logic                in_ld,
    input  logic                in_st,
    input  logic [2:0]          in_funct3,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic [4:0]          in_rd,
    input  logic                in_reg_w_en,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [IDX_W-1:0]    mem_req_idx,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [31:0]         out_ins,
    output logic [4:0]          out_rd,
    output logic                out_reg_w_en,
    output logic [XLEN-1:0]     out_wb_data,
    output logic                out_exc,
    output logic [4:0]          fwd_rd,
    output logic                fwd_wen
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e state_reg, state_next;

    logic              ld_reg;
    logic [2:0]        funct3_reg;
    logic [OFF_W-1:0]  off_reg;
    logic              req_we_reg;
    logic [IDX_W-1:0]  req_idx_reg;
    logic [XLEN-1:0]   req_wdata_reg;
    logic [STRB_W-1:0] req_wstrb_reg;
    logic [XLEN-1:0]   out_pc_reg;
    logic [31:0]       out_ins_reg;
    logic [4:0]        out_rd_reg;
    logic              out_reg_w_en_reg;
    logic [XLEN-1:0]   out_wb_data_reg;
    logic              out_exc_reg;

    logic              accept;
    logic              is_mem;
    logic              misaligned;
    logic [XLEN-1:0]   st_data;
    logic [STRB_W-1:0] st_strb;
    logic [XLEN-1:0]   ld_data;

    assign accept = in_valid && (state_reg == LSU_IDLE);
    assign is_mem = in_ld || in_st;

`ifdef YSYX_22041071_MISALIGN_TRAP_EN
    logic [OFF_W-1:0] size_mask;
    assign size_mask  = OFF_W'(access_bytes(in_funct3) - 4'd1);
    assign misaligned = is_mem && |(in_addr[OFF_W-1:0] & size_mask);
`else
    assign misaligned = 1'b0;
`endif

    ysyx_22041071_lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3 (in_funct3),
        .st_off    (in_addr[OFF_W-1:0]),
        .st_wdata  (in_wdata),
        .st_data   (st_data),
        .st_strb   (st_strb),
        .ld_funct3 (funct3_reg),
        .ld_off    (off_reg),
        .ld_rdata  (mem_rsp_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: if (in_valid) state_next = (is_mem && !misaligned) ? LSU_REQ : LSU_OUT;
            LSU_REQ:  if (mem_req_ready) state_next = ld_reg ? LSU_WAIT : LSU_OUT;
            LSU_WAIT: if (mem_rsp_valid) state_next = LSU_OUT;
            LSU_OUT:  if (out_ready) state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= LSU_IDLE;
            ld_reg           <= 1'b0;
            funct3_reg       <= '0;
            off_reg          <= '0;
            req_we_reg       <= 1'b0;
            req_idx_reg      <= '0;
            req_wdata_reg    <= '0;
            req_wstrb_reg    <= '0;
            out_pc_reg       <= '0;
            out_ins_reg      <= '0;
            out_rd_reg       <= '0;
            out_reg_w_en_reg <= 1'b0;
            out_wb_data_reg  <= '0;
            out_exc_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Identity fields go straight into the output register; they are
            // only visible once the FSM reaches OUT.
            if (accept) begin
                out_pc_reg       <= in_pc;
                out_ins_reg      <= in_ins;
                out_rd_reg       <= in_rd;
                out_reg_w_en_reg <= in_reg_w_en && !misaligned;
                out_wb_data_reg  <= is_mem ? '0 : in_addr;
                out_exc_reg      <= misaligned;
                if (is_mem && !misaligned) begin
                    ld_reg        <= in_ld;
                    funct3_reg    <= in_funct3;
                    off_reg       <= in_addr[OFF_W-1:0];
                    req_we_reg    <= !in_ld;
                    req_idx_reg   <= IDX_W'((in_addr - MEM_BASE) >> OFF_W);
                    req_wdata_reg <= st_data;
                    req_wstrb_reg <= in_ld ? '0 : st_strb;
                end
            end
            if ((state_reg == LSU_WAIT) && mem_rsp_valid) begin
                out_wb_data_reg <= ld_data;
            end
        end
    end

    assign in_ready      = (state_reg == LSU_IDLE);
    assign out_valid     = (state_reg == LSU_OUT);
    assign mem_req_valid = (state_reg == LSU_REQ);
    assign mem_req_we    = req_we_reg;
    assign mem_req_idx   = req_idx_reg;
    assign mem_req_wdata = req_wdata_reg;
    assign mem_req_wstrb = req_wstrb_reg;
    assign out_pc        = out_pc_reg;
    assign out_ins       = out_ins_reg;
    assign out_rd        = out_rd_reg;
    assign out_reg_w_en  = out_reg_w_en_reg;
    assign out_wb_data   = out_wb_data_reg;
    assign out_exc       = out_exc_reg;
    assign fwd_rd        = in_rd;
    assign fwd_wen       = in_reg_w_en;

endmodule

// File: tb/tb_ysyx_22041071_lsu.sv
// Self-checking bench for ysyx_22041071_lsu: directed cases plus random
// traffic checked against a byte-addressed memory reference model.
module tb_ysyx_22041071_lsu;
    import ysyx_22041071_lsu_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;

`ifdef YSYX_22041071_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_ins;
    logic        in_ld, in_st;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_w_en;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [60:0] mem_req_idx;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        out_valid, out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_ins;
    logic [4:0]  out_rd;
    logic        out_reg_w_en;
    logic [63:0] out_wb_data;
    logic        out_exc;
    logic [4:0]  fwd_rd;
    logic        fwd_wen;

    int total = 0;
    int bad = 0;
    logic [7:0] mem_b [0:255];

    always #5 clk = ~clk;

    ysyx_22041071_lsu dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
        .in_ld(in_ld), .in_st(in_st), .in_funct3(in_funct3), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .in_reg_w_en(in_reg_w_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_idx(mem_req_idx), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
        .out_rd(out_rd), .out_reg_w_en(out_reg_w_en), .out_wb_data(out_wb_data),
        .out_exc(out_exc), .fwd_rd(fwd_rd), .fwd_wen(fwd_wen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input int widx);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = mem_b[widx*8 + b];
        return w;
    endfunction

    // Reference load: gather n bytes little-endian from the size-aligned
    // address, then extend according to the signedness of funct3.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr);
        int n;
        int a;
        logic [63:0] v;
        if (f3 == 3'b111) return 64'd0;
        n = 1 << f3[1:0];
        a = int'(addr - BASE) & ~(n - 1);
        v = 64'd0;
        for (int i = 0; i < n; i++) v |= 64'(mem_b[a + i]) << (8 * i);
        if (!f3[2] && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input int rdy_dly, input int rsp_dly, input int out_dly);
        logic [63:0] pc, exp_wb, exp_wdata;
        logic [31:0] ins;
        logic [4:0]  rd;
        logic        wen, trap;
        logic [7:0]  exp_strb;
        logic [60:0] exp_idx;
        int          n, off;
        pc  = {$urandom, $urandom};
        ins = {25'($urandom), ld ? OPC_LOAD : (st ? OPC_STORE : 7'b0010011)};
        rd  = 5'($urandom);
        wen = 1'($urandom);
        n   = 1 << f3[1:0];
        trap = TRAP_EN && (ld || st) && ((int'(addr[2:0]) % n) != 0);
        off = int'(addr[2:0]) & ~(n - 1);
        exp_idx = 61'((addr - BASE) >> 3);
        exp_wdata = wdata << (8 * off);
        exp_strb = 8'd0;
        if (st && !f3[2]) for (int i = 0; i < n; i++) exp_strb[off + i] = 1'b1;

        in_valid = 1'b1; in_pc = pc; in_ins = ins; in_ld = ld; in_st = st;
        in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_rd = rd; in_reg_w_en = wen;
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        check("fwd_rd", 64'(fwd_rd), 64'(rd));
        check("fwd_wen", 64'(fwd_wen), 64'(wen));
        tick();
        in_valid = 1'b0;

        if ((ld || st) && !trap) begin
            for (int c = 0; c <= rdy_dly; c++) begin
                check("req_valid", 64'(mem_req_valid), 64'd1);
                check("req_idx", 64'(mem_req_idx), 64'(exp_idx));
                check("req_we", 64'(mem_req_we), 64'(st));
                if (st) check("req_wstrb", 64'(mem_req_wstrb), 64'(exp_strb));
                if (st && exp_strb != 8'd0) check("req_wdata", mem_req_wdata, exp_wdata);
                check("busy_in_ready", 64'(in_ready), 64'd0);
                check("busy_out_valid", 64'(out_valid), 64'd0);
                if (c == rdy_dly) begin
                    mem_req_ready = 1'b1;
                    mem_rsp_valid = 1'b0;
                end else begin
                    mem_rsp_valid = 1'($urandom);
                    mem_rsp_rdata = {$urandom, $urandom};
                end
                tick();
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            check("req_dropped", 64'(mem_req_valid), 64'd0);
            if (ld) begin
                exp_wb = model_load(f3, addr);
                for (int c = 0; c <= rsp_dly; c++) begin
                    check("wait_out_valid", 64'(out_valid), 64'd0);
                    check("wait_req_valid", 64'(mem_req_valid), 64'd0);
                    if (c == rsp_dly) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = word_at(int'(exp_idx));
                    end
                    tick();
                end
                mem_rsp_valid = 1'b0;
            end else begin
                exp_wb = 64'd0;
                for (int b = 0; b < 8; b++)
                    if (exp_strb[b]) mem_b[int'(exp_idx)*8 + b] = exp_wdata[8*b +: 8];
            end
        end else begin
            check("trap_no_req", 64'(mem_req_valid), 64'd0);
            exp_wb = (ld || st) ? 64'd0 : addr;
        end

        check("out_valid", 64'(out_valid), 64'd1);
        check("out_pc", out_pc, pc);
        check("out_ins", 64'(out_ins), 64'(ins));
        check("out_rd", 64'(out_rd), 64'(rd));
        check("out_reg_w_en", 64'(out_reg_w_en), 64'(wen && !trap));
        check("out_exc", 64'(out_exc), 64'(trap));
        if (!trap) check("out_wb_data", out_wb_data, exp_wb);

        for (int c = 0; c < out_dly; c++) begin
            in_valid = 1'b1;
            tick();
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_no_req", 64'(mem_req_valid), 64'd0);
            check("hold_pc", out_pc, pc);
            if (!trap) check("hold_wb", out_wb_data, exp_wb);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        $display("op ld=%0d st=%0d f3=%0d addr=%h wb=%h exc=%0d", ld, st, f3, addr, out_wb_data, out_exc);
    endtask

    initial begin
        logic [2:0] rf3;
        int kind;
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_ins = '0; in_ld = 1'b0; in_st = 1'b0;
        in_funct3 = '0; in_addr = '0; in_wdata = '0; in_rd = '0; in_reg_w_en = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        for (int b = 0; b < 8; b++) mem_b[b] = 8'((64'h00AB_8000_0000_0000 >> (8 * b)) & 64'hFF);
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_exc", 64'(out_exc), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_ins", 64'(out_ins), 64'd0);
        check("rst_out_wb", out_wb_data, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_wen", 64'(out_reg_w_en), 64'd0);
        check("rst_req_idx", 64'(mem_req_idx), 64'd0);
        check("rst_req_wdata", mem_req_wdata, 64'd0);
        check("rst_req_wstrb", 64'(mem_req_wstrb), 64'd0);
        check("rst_req_we", 64'(mem_req_we), 64'd0);
        reset = 1'b0;
        $display("reset released");

        run_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 0, 0, 0);
        run_op(1'b1, 1'b0, F3_LB, BASE + 64'd5, 64'd0, 0, 0, 0);
        run_op(1'b1, 1'b0, F3_LBU, BASE + 64'd5, 64'd0, 0, 0, 0);
        run_op(1'b0, 1'b1, F3_SH, BASE + 64'd6, 64'hBEEF, 0, 0, 0);
        run_op(1'b1, 1'b0, F3_LHU, BASE + 64'd6, 64'd0, 0, 0, 0);
        run_op(1'b1, 1'b0, F3_LD, BASE + 64'd8, 64'd0, 3, 4, 0);
        run_op(1'b0, 1'b1, F3_SD, BASE + 64'd16, 64'h0123_4567_89AB_CDEF, 3, 0, 0);
        run_op(1'b0, 1'b0, 3'b000, 64'hDEAD_0000_CAFE, 64'd0, 0, 0, 5);
        run_op(1'b1, 1'b0, F3_LW, BASE + 64'd2, 64'd0, 0, 0, 0);
        run_op(1'b1, 1'b0, F3_LH, BASE + 64'd3, 64'd0, 1, 1, 2);
        run_op(1'b0, 1'b1, F3_SW, BASE + 64'd29, 64'hFFFF_FFFF_8765_4321, 0, 0, 0);
        run_op(1'b1, 1'b0, F3_LWU, BASE + 64'd28, 64'd0, 0, 2, 0);
        run_op(1'b1, 1'b0, 3'b111, BASE + 64'd8, 64'd0, 0, 0, 0);
        run_op(1'b0, 1'b1, 3'b111, BASE + 64'd8, 64'hFFFF, 0, 0, 0);
        run_op(1'b0, 1'b1, F3_SB, BASE + 64'd33, 64'h5A, 0, 0, 0);

        // Reset while waiting for a response; the late response must be ignored.
        in_valid = 1'b1; in_ld = 1'b1; in_st = 1'b0; in_funct3 = F3_LD; in_addr = BASE + 64'd40;
        mem_req_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        check("wait_state_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_rsp_valid = 1'b0;
        check("stray_out_valid", 64'(out_valid), 64'd0);
        check("stray_in_ready", 64'(in_ready), 64'd1);
        check("stray_req_valid", 64'(mem_req_valid), 64'd0);
        $display("reset-in-wait step done");

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            rf3 = 3'($urandom);
            if (kind == 2 && rf3[2] && rf3 != 3'b111) rf3 = {1'b0, rf3[1:0]};
            run_op(kind == 1, kind == 2, rf3,
                   (kind == 0) ? {$urandom, $urandom} : BASE + 64'($urandom_range(0, 255)),
                   {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
